xprs: RTL and testbench



---
 rtl/xprs_pkg.sv | 12 +
 rtl/xprs_read_port.sv | 35 +++
 rtl/xprs.sv | 66 ++++++
 tb/tb_xprs.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/xprs_pkg.sv
// Shared constants and types for the xprs integer register file.
package xprs_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_XPRS     = 32;

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

endpackage

// File: rtl/xprs_read_port.sv
// One asynchronous read port of the xprs register file: address decode,
// x0 zero-forcing and, when XPRS_BYPASS_EN is defined, write-through
// forwarding of the in-flight write data.
module xprs_read_port
  import xprs_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0]          rs_i,
  input  logic [NUM_XPRS-1:1][XLEN-1:0]  regs_i,
`ifdef XPRS_BYPASS_EN
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [REG_ADDR_W-1:0]          rd_i,
  input  logic [XLEN-1:0]                d_i,
`endif
  output logic [XLEN-1:0]                q_o
);

  // Select stored value; address 0 has no storage and falls through to zero.
  always_comb begin
    q_o = '0;
    for (int unsigned i = 1; i < NUM_XPRS; i++) begin
      if (rs_i == REG_ADDR_W'(i)) begin
        q_o = regs_i[i];
      end
    end
`ifdef XPRS_BYPASS_EN
    if (we_i && !rst_i && (rd_i != X0) && (rd_i == rs_i)) begin
      q_o = d_i;
    end
`endif
  end

endmodule

// File: rtl/xprs.sv
// xprs: 31 x XLEN general-purpose registers (x0 hardwired to zero), two
// combinational read ports and one synchronous write port.
// Optional build macro: XPRS_BYPASS_EN enables write-through forwarding on
// both read ports.
module xprs
  import xprs_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       d_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic [XLEN-1:0]       q1_o,
  output logic [XLEN-1:0]       q2_o
);

  // x1..x31 only; x0 is never stored.
  logic [NUM_XPRS-1:1][XLEN-1:0] regs;

  // Synchronous reset clears all storage and overrides a same-cycle write;
  // writes to x0 match no entry and are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs <= '0;
    end else if (we_i) begin
      for (int unsigned i = 1; i < NUM_XPRS; i++) begin
        if (rd_i == REG_ADDR_W'(i)) begin
          regs[i] <= d_i;
        end
      end
    end
  end

  xprs_read_port #(
    .XLEN (XLEN)
  ) u_rp1 (
    .rs_i   (rs1_i),
    .regs_i (regs),
`ifdef XPRS_BYPASS_EN
    .rst_i  (rst_i),
    .we_i   (we_i),
    .rd_i   (rd_i),
    .d_i    (d_i),
`endif
    .q_o    (q1_o)
  );

  xprs_read_port #(
    .XLEN (XLEN)
  ) u_rp2 (
    .rs_i   (rs2_i),
    .regs_i (regs),
`ifdef XPRS_BYPASS_EN
    .rst_i  (rst_i),
    .we_i   (we_i),
    .rd_i   (rd_i),
    .d_i    (d_i),
`endif
    .q_o    (q2_o)
  );

endmodule

// File: tb/tb_xprs.sv
// Directed self-checking bench for the xprs register file.
module tb_xprs;

  localparam logic [63:0] DEAD = 64'hDEADBEEFFEEDFACE;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        we_i;
  logic [4:0]  rd_i;
  logic [63:0] d_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [63:0] q1_o;
  logic [63:0] q2_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  xprs #(
    .XLEN (64)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (we_i),
    .rd_i  (rd_i),
    .d_i   (d_i),
    .rs1_i (rs1_i),
    .rs2_i (rs2_i),
    .q1_o  (q1_o),
    .q2_o  (q2_o)
  );

  always #5 clk_i = ~clk_i;

  // Fill pattern: x1..x15 -> nibble 1..F repeated, x16..x29 -> nibble 1..E,
  // x30 -> 1111..., x31 -> 0, x0 -> 0.
  function automatic logic [63:0] pat(input int unsigned n);
    logic [3:0] nib;
    if (n == 0 || n == 31) nib = 4'h0;
    else if (n == 30)      nib = 4'h1;
    else if (n <= 15)      nib = 4'(n);
    else                   nib = 4'(n - 15);
    return {16{nib}};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; we_i = 1'b0; rd_i = '0; d_i = '0; rs1_i = '0; rs2_i = '0;
    tick();
    rst_i = 1'b0;

    // Reset state: every address reads zero on both ports.
    for (int n = 0; n < 32; n++) begin
      rs1_i = 5'(n); rs2_i = 5'(31 - n); #1;
      check($sformatf("reset_q1_x%0d", n), q1_o, 64'h0);
      check($sformatf("reset_q2_x%0d", 31 - n), q2_o, 64'h0);
    end

    // Write gating.
    rd_i = 5'd1; d_i = DEAD; we_i = 1'b0; rs1_i = 5'd1;
    tick();
    check("gate_we0", q1_o, 64'h0);
    we_i = 1'b1;
    tick();
    we_i = 1'b0;
    check("gate_we1", q1_o, DEAD);

    // Fill x1..x31, then attempt to write x0.
    we_i = 1'b1;
    for (int n = 1; n < 32; n++) begin
      rd_i = 5'(n); d_i = pat(n);
      tick();
    end
    rd_i = 5'd0; d_i = 64'h0;
    tick();
    rd_i = 5'd0; d_i = DEAD;
    tick();
    we_i = 1'b0;
    for (int n = 0; n < 32; n++) begin
      rs1_i = 5'(n); rs2_i = 5'((n + 7) % 32); #1;
      check($sformatf("fill_q1_x%0d", n), q1_o, pat(n));
      check($sformatf("fill_q2_x%0d", (n + 7) % 32), q2_o, pat((n + 7) % 32));
    end

    // Dual-port independence.
    rs1_i = 5'd3; rs2_i = 5'd30; #1;
    check("dual_q1_x3", q1_o, 64'h3333333333333333);
    check("dual_q2_x30", q2_o, 64'h1111111111111111);

    // Read-during-write on every address.
    for (int n = 0; n < 32; n++) begin
      rd_i = 5'(n); rs1_i = 5'(n); rs2_i = 5'(n); we_i = 1'b1; d_i = DEAD;
      #1;
`ifdef XPRS_BYPASS_EN
      check($sformatf("rdw_pre_q1_x%0d", n), q1_o, (n == 0) ? 64'h0 : DEAD);
      check($sformatf("rdw_pre_q2_x%0d", n), q2_o, (n == 0) ? 64'h0 : DEAD);
`else
      check($sformatf("rdw_pre_q1_x%0d", n), q1_o, pat(n));
      check($sformatf("rdw_pre_q2_x%0d", n), q2_o, pat(n));
`endif
      tick();
      we_i = 1'b0; #1;
      check($sformatf("rdw_post_q1_x%0d", n), q1_o, (n == 0) ? 64'h0 : DEAD);
      check($sformatf("rdw_post_q2_x%0d", n), q2_o, (n == 0) ? 64'h0 : DEAD);
    end

    // Reset overrides a same-cycle write.
    we_i = 1'b1; rd_i = 5'd5; d_i = 64'h5555555555555555;
    tick();
    we_i = 1'b0; rs1_i = 5'd5; #1;
    check("preload_x5", q1_o, 64'h5555555555555555);
    rst_i = 1'b1; we_i = 1'b1; rd_i = 5'd6; d_i = 64'h0123456789ABCDEF;
    tick();
    rst_i = 1'b0; we_i = 1'b0;
    rs1_i = 5'd5; rs2_i = 5'd6; #1;
    check("rst_x5", q1_o, 64'h0);
    check("rst_x6", q2_o, 64'h0);
    rs1_i = 5'd31; rs2_i = 5'd1; #1;
    check("rst_x31", q1_o, 64'h0);
    check("rst_x1", q2_o, 64'h0);

`ifdef XPRS_BYPASS_EN
    // Write-through forwarding.
    rd_i = 5'd7; rs1_i = 5'd7; we_i = 1'b1; d_i = 64'hCAFE; #1;
    check("byp_x7", q1_o, 64'hCAFE);
    rd_i = 5'd0; rs1_i = 5'd0; #1;
    check("byp_x0", q1_o, 64'h0);
    we_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
